// File: rtl/mem_rs.sv
// Memory reservation station: holds load/store ops until both operands are ready and issues one per cycle to the LSB.
// Optional MRS_CDB_BYPASS_EN: lets eligibility see same-cycle broadcasts and dispatch, which saves one cycle of latency.
module mem_rs #(
  parameter int MRS_SIZE  = 4,
  parameter int MRS_WIDTH = 2,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 from_decoder,
  input  logic [3:0]           from_decoder_op,
  input  logic [ROB_WIDTH-1:0] from_decoder_tag,
  input  logic                 from_decoder_rs1_rdy,
  input  logic                 from_decoder_rs2_rdy,
  input  logic [31:0]          from_decoder_rs1_val,
  input  logic [31:0]          from_decoder_rs2_val,
  input  logic [ROB_WIDTH-1:0] from_decoder_rs1_dep,
  input  logic [ROB_WIDTH-1:0] from_decoder_rs2_dep,
  input  logic [31:0]          from_decoder_imm,
  input  logic                 alu_cdb,
  input  logic [ROB_WIDTH-1:0] alu_cdb_tag,
  input  logic [31:0]          alu_cdb_data,
  input  logic                 lsb_cdb,
  input  logic [ROB_WIDTH-1:0] lsb_cdb_tag,
  input  logic [31:0]          lsb_cdb_data,
  output logic                 to_lsb,
  output logic [3:0]           to_lsb_op,
  output logic [ROB_WIDTH-1:0] to_lsb_tag,
  output logic [31:0]          to_lsb_address,
  output logic [31:0]          to_lsb_wdata,
  output logic                 to_decoder_full
);

  localparam logic [3:0] FIRST_STORE_OP = 4'd5;

  logic [MRS_SIZE-1:0]  valid_r;
  logic [3:0]           op_r      [MRS_SIZE];
  logic [ROB_WIDTH-1:0] tag_r     [MRS_SIZE];
  logic [31:0]          imm_r     [MRS_SIZE];
  logic [MRS_SIZE-1:0]  rs1_rdy_r;
  logic [MRS_SIZE-1:0]  rs2_rdy_r;
  logic [31:0]          rs1_val_r [MRS_SIZE];
  logic [31:0]          rs2_val_r [MRS_SIZE];
  logic [ROB_WIDTH-1:0] rs1_dep_r [MRS_SIZE];
  logic [ROB_WIDTH-1:0] rs2_dep_r [MRS_SIZE];

  logic [MRS_SIZE-1:0]  valid_s;
  logic [3:0]           op_s      [MRS_SIZE];
  logic [ROB_WIDTH-1:0] tag_s     [MRS_SIZE];
  logic [31:0]          imm_s     [MRS_SIZE];
  logic [MRS_SIZE-1:0]  rs1_rdy_s;
  logic [MRS_SIZE-1:0]  rs2_rdy_s;
  logic [31:0]          rs1_val_s [MRS_SIZE];
  logic [31:0]          rs2_val_s [MRS_SIZE];
  logic [ROB_WIDTH-1:0] rs1_dep_s [MRS_SIZE];
  logic [ROB_WIDTH-1:0] rs2_dep_s [MRS_SIZE];

  logic                 free_found_s;
  logic [MRS_WIDTH-1:0] free_idx_s;
  logic                 dispatch_en_s;
  logic [MRS_SIZE-1:0]  elig_s;
  logic                 issue_found_s;
  logic [MRS_WIDTH-1:0] issue_idx_s;
  logic [31:0]          issue_addr_s;
  logic [31:0]          issue_wdata_s;
  logic [MRS_SIZE-1:0]  valid_fin_s;
  logic [MRS_WIDTH:0]   count_s;
  logic                 full_s;

  // Operand wakeup: returns {ready, value}; the ALU broadcast has priority over the LSB broadcast.
  function automatic logic [32:0] wake(input logic rdy, input logic [31:0] val,
                                       input logic [ROB_WIDTH-1:0] dep);
    logic [32:0] res;
    if (rdy) begin
      res = {1'b1, val};
    end else if (alu_cdb && (alu_cdb_tag == dep)) begin
      res = {1'b1, alu_cdb_data};
    end else if (lsb_cdb && (lsb_cdb_tag == dep)) begin
      res = {1'b1, lsb_cdb_data};
    end else begin
      res = {1'b0, val};
    end
    return res;
  endfunction

  // Lowest-index free slot, judged before this edge's issue invalidation.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = MRS_SIZE - 1; i >= 0; i--) begin
      if (!valid_r[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = MRS_WIDTH'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
    dispatch_en_s = from_decoder && free_found_s;
  end

  // Next entry contents: broadcast wakeup on stored entries, dispatch written into the free slot.
  always_comb begin
    for (int i = 0; i < MRS_SIZE; i++) begin
      if (dispatch_en_s && (free_idx_s == MRS_WIDTH'(i))) begin
        valid_s[i]   = 1'b1;
        op_s[i]      = from_decoder_op;
        tag_s[i]     = from_decoder_tag;
        imm_s[i]     = from_decoder_imm;
        rs1_dep_s[i] = from_decoder_rs1_dep;
        rs2_dep_s[i] = from_decoder_rs2_dep;
        {rs1_rdy_s[i], rs1_val_s[i]} = wake(from_decoder_rs1_rdy, from_decoder_rs1_val,
                                            from_decoder_rs1_dep);
        if (from_decoder_op < FIRST_STORE_OP) begin
          rs2_rdy_s[i] = 1'b1;
          rs2_val_s[i] = 32'd0;
        end else begin
          {rs2_rdy_s[i], rs2_val_s[i]} = wake(from_decoder_rs2_rdy, from_decoder_rs2_val,
                                              from_decoder_rs2_dep);
        end
      end else begin
        valid_s[i]   = valid_r[i];
        op_s[i]      = op_r[i];
        tag_s[i]     = tag_r[i];
        imm_s[i]     = imm_r[i];
        rs1_dep_s[i] = rs1_dep_r[i];
        rs2_dep_s[i] = rs2_dep_r[i];
        {rs1_rdy_s[i], rs1_val_s[i]} = wake(rs1_rdy_r[i], rs1_val_r[i], rs1_dep_r[i]);
        {rs2_rdy_s[i], rs2_val_s[i]} = wake(rs2_rdy_r[i], rs2_val_r[i], rs2_dep_r[i]);
      end
    end
  end

  // Issue select; a stored-ready entry keeps its values through wakeup, so the _s view serves both builds.
  always_comb begin
`ifdef MRS_CDB_BYPASS_EN
    elig_s = valid_s & rs1_rdy_s & rs2_rdy_s;
`else
    elig_s = valid_r & rs1_rdy_r & rs2_rdy_r;
`endif
    issue_found_s = 1'b0;
    issue_idx_s   = '0;
    for (int i = MRS_SIZE - 1; i >= 0; i--) begin
      if (elig_s[i]) begin
        issue_found_s = 1'b1;
        issue_idx_s   = MRS_WIDTH'(i);
      end else begin
        issue_found_s = issue_found_s;
      end
    end
    issue_addr_s = rs1_val_s[issue_idx_s] + imm_s[issue_idx_s];
    if (op_s[issue_idx_s] >= FIRST_STORE_OP) begin
      issue_wdata_s = rs2_val_s[issue_idx_s];
    end else begin
      issue_wdata_s = 32'd0;
    end
    count_s = '0;
    for (int i = 0; i < MRS_SIZE; i++) begin
      valid_fin_s[i] = valid_s[i] & ~(issue_found_s && (issue_idx_s == MRS_WIDTH'(i)));
      count_s        = count_s + {{MRS_WIDTH{1'b0}}, valid_fin_s[i]};
    end
    full_s = (int'(count_s) + 2) > MRS_SIZE;
  end

  // State and output registers; rdy_in low freezes everything, reset included.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (rst_in) begin
        valid_r         <= '0;
        to_lsb          <= 1'b0;
        to_lsb_op       <= 4'd0;
        to_lsb_tag      <= '0;
        to_lsb_address  <= 32'd0;
        to_lsb_wdata    <= 32'd0;
        to_decoder_full <= 1'b0;
      end else if (clear) begin
        valid_r         <= '0;
        to_lsb          <= 1'b0;
        to_decoder_full <= 1'b0;
      end else begin
        valid_r         <= valid_fin_s;
        rs1_rdy_r       <= rs1_rdy_s;
        rs2_rdy_r       <= rs2_rdy_s;
        for (int i = 0; i < MRS_SIZE; i++) begin
          op_r[i]      <= op_s[i];
          tag_r[i]     <= tag_s[i];
          imm_r[i]     <= imm_s[i];
          rs1_val_r[i] <= rs1_val_s[i];
          rs2_val_r[i] <= rs2_val_s[i];
          rs1_dep_r[i] <= rs1_dep_s[i];
          rs2_dep_r[i] <= rs2_dep_s[i];
        end
        to_lsb          <= issue_found_s;
        to_decoder_full <= full_s;
        if (issue_found_s) begin
          to_lsb_op      <= op_s[issue_idx_s];
          to_lsb_tag     <= tag_s[issue_idx_s];
          to_lsb_address <= issue_addr_s;
          to_lsb_wdata   <= issue_wdata_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_rs.sv
// Directed self-checking bench for mem_rs (default build, no bypass).
module tb_mem_rs;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        from_decoder;
  logic [3:0]  from_decoder_op, from_decoder_tag;
  logic        from_decoder_rs1_rdy, from_decoder_rs2_rdy;
  logic [31:0] from_decoder_rs1_val, from_decoder_rs2_val;
  logic [3:0]  from_decoder_rs1_dep, from_decoder_rs2_dep;
  logic [31:0] from_decoder_imm;
  logic        alu_cdb, lsb_cdb;
  logic [3:0]  alu_cdb_tag, lsb_cdb_tag;
  logic [31:0] alu_cdb_data, lsb_cdb_data;
  logic        to_lsb, to_decoder_full;
  logic [3:0]  to_lsb_op, to_lsb_tag;
  logic [31:0] to_lsb_address, to_lsb_wdata;

  int total = 0;
  int bad   = 0;

  mem_rs #(.MRS_SIZE(4), .MRS_WIDTH(2), .ROB_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .from_decoder(from_decoder), .from_decoder_op(from_decoder_op),
    .from_decoder_tag(from_decoder_tag),
    .from_decoder_rs1_rdy(from_decoder_rs1_rdy), .from_decoder_rs2_rdy(from_decoder_rs2_rdy),
    .from_decoder_rs1_val(from_decoder_rs1_val), .from_decoder_rs2_val(from_decoder_rs2_val),
    .from_decoder_rs1_dep(from_decoder_rs1_dep), .from_decoder_rs2_dep(from_decoder_rs2_dep),
    .from_decoder_imm(from_decoder_imm),
    .alu_cdb(alu_cdb), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
    .lsb_cdb(lsb_cdb), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_data(lsb_cdb_data),
    .to_lsb(to_lsb), .to_lsb_op(to_lsb_op), .to_lsb_tag(to_lsb_tag),
    .to_lsb_address(to_lsb_address), .to_lsb_wdata(to_lsb_wdata),
    .to_decoder_full(to_decoder_full)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    from_decoder = 1'b0;
    alu_cdb = 1'b0;
    lsb_cdb = 1'b0;
    clear = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [3:0] tag,
                      input logic r1rdy, input logic [31:0] r1val, input logic [3:0] r1dep,
                      input logic r2rdy, input logic [31:0] r2val, input logic [3:0] r2dep,
                      input logic [31:0] imm);
    from_decoder = 1'b1;
    from_decoder_op = op;
    from_decoder_tag = tag;
    from_decoder_rs1_rdy = r1rdy;
    from_decoder_rs1_val = r1val;
    from_decoder_rs1_dep = r1dep;
    from_decoder_rs2_rdy = r2rdy;
    from_decoder_rs2_val = r2val;
    from_decoder_rs2_dep = r2dep;
    from_decoder_imm = imm;
  endtask

  task automatic alu(input logic [3:0] tag, input logic [31:0] data);
    alu_cdb = 1'b1;
    alu_cdb_tag = tag;
    alu_cdb_data = data;
  endtask

  task automatic lsb(input logic [3:0] tag, input logic [31:0] data);
    lsb_cdb = 1'b1;
    lsb_cdb_tag = tag;
    lsb_cdb_data = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rdy_in = 1'b1;
    rst_in = 1'b1;
    disp(4'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0);
    alu_cdb_tag = 4'd0; alu_cdb_data = 32'd0;
    lsb_cdb_tag = 4'd0; lsb_cdb_data = 32'd0;
    idle();
    tick(); tick();
    chk("rst_to_lsb", {31'd0, to_lsb}, 32'd0);
    chk("rst_full", {31'd0, to_decoder_full}, 32'd0);
    chk("rst_op", {28'd0, to_lsb_op}, 32'd0);
    chk("rst_tag", {28'd0, to_lsb_tag}, 32'd0);
    chk("rst_addr", to_lsb_address, 32'd0);
    chk("rst_wdata", to_lsb_wdata, 32'd0);
    rst_in = 1'b0;

    // LW, both operands ready: pulse one cycle after the dispatch edge
    disp(4'd4, 4'd3, 1'b1, 32'h1000, 4'd0, 1'b0, 32'd0, 4'd0, 32'd8);
    tick(); idle();
    chk("lw_wait", {31'd0, to_lsb}, 32'd0);
    tick();
    chk("lw_valid", {31'd0, to_lsb}, 32'd1);
    chk("lw_addr", to_lsb_address, 32'h1008);
    chk("lw_op", {28'd0, to_lsb_op}, 32'd4);
    chk("lw_tag", {28'd0, to_lsb_tag}, 32'd3);
    chk("lw_wdata", to_lsb_wdata, 32'd0);
    tick();
    chk("lw_pulse", {31'd0, to_lsb}, 32'd0);

    // SW waiting on rs2, ALU wakeup two cycles later
    disp(4'd7, 4'd5, 1'b1, 32'h20, 4'd0, 1'b0, 32'd0, 4'd2, 32'hFFFF_FFFC);
    tick(); idle();
    chk("sw_wait0", {31'd0, to_lsb}, 32'd0);
    tick();
    chk("sw_wait1", {31'd0, to_lsb}, 32'd0);
    alu(4'd2, 32'hDEAD_BEEF);
    tick(); idle();
    chk("sw_wake", {31'd0, to_lsb}, 32'd0);
    tick();
    chk("sw_valid", {31'd0, to_lsb}, 32'd1);
    chk("sw_addr", to_lsb_address, 32'h1C);
    chk("sw_wdata", to_lsb_wdata, 32'hDEAD_BEEF);
    chk("sw_tag", {28'd0, to_lsb_tag}, 32'd5);
    chk("sw_op", {28'd0, to_lsb_op}, 32'd7);
    tick();
    chk("sw_pulse", {31'd0, to_lsb}, 32'd0);

    // Fill all four entries waiting on tag 7, then release in index order
    for (int i = 0; i < 4; i++) begin
      disp(4'd0, 4'(8 + i), 1'b0, 32'd0, 4'd7, 1'b0, 32'd0, 4'd0, 32'(4 * i));
      tick();
      chk("fill_full", {31'd0, to_decoder_full}, (i >= 2) ? 32'd1 : 32'd0);
    end
    idle();
    lsb(4'd7, 32'h100);
    tick(); idle();
    chk("fill_wake", {31'd0, to_lsb}, 32'd0);
    chk("fill_wake_full", {31'd0, to_decoder_full}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_valid", {31'd0, to_lsb}, 32'd1);
      chk("drain_tag", {28'd0, to_lsb_tag}, 32'(8 + i));
      chk("drain_addr", to_lsb_address, 32'h100 + 32'(4 * i));
      chk("drain_full", {31'd0, to_decoder_full}, (i == 0) ? 32'd1 : 32'd0);
    end
    tick();
    chk("drain_end", {31'd0, to_lsb}, 32'd0);

    // Both broadcasts match the same operand: ALU data wins
    disp(4'd5, 4'd4, 1'b1, 32'h40, 4'd0, 1'b0, 32'd0, 4'd1, 32'd0);
    tick(); idle();
    alu(4'd1, 32'h11);
    lsb(4'd1, 32'h22);
    tick(); idle();
    chk("prio_wait", {31'd0, to_lsb}, 32'd0);
    tick();
    chk("prio_valid", {31'd0, to_lsb}, 32'd1);
    chk("prio_wdata", to_lsb_wdata, 32'h11);
    chk("prio_addr", to_lsb_address, 32'h40);

    // Clear with a matching broadcast and a dispatch in the same cycle
    disp(4'd0, 4'd1, 1'b0, 32'd0, 4'd3, 1'b0, 32'd0, 4'd0, 32'd0);
    tick();
    disp(4'd0, 4'd2, 1'b0, 32'd0, 4'd3, 1'b0, 32'd0, 4'd0, 32'd0);
    tick();
    disp(4'd0, 4'd6, 1'b1, 32'h600, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0);
    alu(4'd3, 32'h500);
    clear = 1'b1;
    tick(); idle();
    chk("clr_to_lsb", {31'd0, to_lsb}, 32'd0);
    chk("clr_full", {31'd0, to_decoder_full}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_quiet", {31'd0, to_lsb}, 32'd0);
    end
    alu(4'd3, 32'h500);
    tick(); idle();
    tick();
    chk("clr_stale", {31'd0, to_lsb}, 32'd0);
    disp(4'd0, 4'd7, 1'b0, 32'd0, 4'd9, 1'b0, 32'd0, 4'd0, 32'd0);
    tick();
    disp(4'd0, 4'd8, 1'b0, 32'd0, 4'd9, 1'b0, 32'd0, 4'd0, 32'd4);
    tick(); idle();
    chk("clr_refill_full", {31'd0, to_decoder_full}, 32'd0);
    lsb(4'd9, 32'h700);
    tick(); idle();
    tick();
    chk("clr_first_tag", {28'd0, to_lsb_tag}, 32'd7);
    chk("clr_first_addr", to_lsb_address, 32'h700);
    tick();
    chk("clr_second_tag", {28'd0, to_lsb_tag}, 32'd8);
    chk("clr_second_addr", to_lsb_address, 32'h704);
    tick();
    chk("clr_done", {31'd0, to_lsb}, 32'd0);

    // rdy_in low: broadcasts ignored, state and outputs frozen
    disp(4'd0, 4'd12, 1'b0, 32'd0, 4'd6, 1'b0, 32'd0, 4'd0, 32'h10);
    tick(); idle();
    rdy_in = 1'b0;
    alu(4'd6, 32'h2000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_ignore", {31'd0, to_lsb}, 32'd0);
    end
    rdy_in = 1'b1;
    idle();
    tick(); tick();
    chk("frz_no_wake", {31'd0, to_lsb}, 32'd0);
    alu(4'd6, 32'h2000);
    tick(); idle();
    chk("frz_wake", {31'd0, to_lsb}, 32'd0);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_hold", {31'd0, to_lsb}, 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    chk("frz_resume", {31'd0, to_lsb}, 32'd1);
    chk("frz_addr", to_lsb_address, 32'h2010);
    chk("frz_tag", {28'd0, to_lsb_tag}, 32'd12);
    rdy_in = 1'b0;
    tick();
    chk("frz_out_held", {31'd0, to_lsb}, 32'd1);
    rdy_in = 1'b1;
    tick();
    chk("frz_out_drop", {31'd0, to_lsb}, 32'd0);

    // Reset while a wakeup broadcast is pending
    disp(4'd0, 4'd13, 1'b0, 32'd0, 4'd5, 1'b0, 32'd0, 4'd0, 32'd0);
    tick(); idle();
    rst_in = 1'b1;
    alu(4'd5, 32'd1);
    tick(); idle();
    rst_in = 1'b0;
    chk("rstw_to_lsb", {31'd0, to_lsb}, 32'd0);
    chk("rstw_addr", to_lsb_address, 32'd0);
    tick(); tick();
    chk("rstw_quiet", {31'd0, to_lsb}, 32'd0);

    // Dispatch operand captured from a same-cycle broadcast
    disp(4'd7, 4'd14, 1'b1, 32'h300, 4'd0, 1'b0, 32'd0, 4'd8, 32'd0);
    alu(4'd8, 32'hCAFE);
    tick(); idle();
    chk("byp_wait", {31'd0, to_lsb}, 32'd0);
    tick();
    chk("byp_valid", {31'd0, to_lsb}, 32'd1);
    chk("byp_wdata", to_lsb_wdata, 32'hCAFE);
    chk("byp_addr", to_lsb_address, 32'h300);

    // Dispatch while all entries are occupied is dropped
    for (int i = 0; i < 4; i++) begin
      disp(4'd0, 4'(i), 1'b0, 32'd0, 4'd10, 1'b0, 32'd0, 4'd0, 32'd0);
      tick();
    end
    disp(4'd0, 4'd15, 1'b1, 32'h900, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0);
    tick(); idle();
    chk("ovf_full", {31'd0, to_decoder_full}, 32'd1);
    tick();
    chk("ovf_dropped", {31'd0, to_lsb}, 32'd0);
    clear = 1'b1;
    tick(); idle();
    chk("ovf_clear_full", {31'd0, to_decoder_full}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_rs.md
MEM_RS -- requirements
Module: mem_rs

Interface
REQ-001 SHALL have parameter MRS_SIZE, default 4, entry count (power of two).
REQ-002 SHALL have parameter MRS_WIDTH, default 2, log2(MRS_SIZE).
REQ-003 SHALL have parameter ROB_WIDTH, default 4, ROB tag width.
REQ-004 SHALL have ports:
- clk_in  in  1  clock; one clock only
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  global enable; low freezes all state and outputs
- clear  in  1  flush on mispredict
- from_decoder  in  1  dispatch valid
- from_decoder_op  in  4  memory op, LSB encoding (LB=0 .. SW=7)
- from_decoder_tag  in  ROB_WIDTH  ROB tag
- from_decoder_rs1_rdy / rs2_rdy  in  1  operand value valid
- from_decoder_rs1_val / rs2_val  in  32  operand value
- from_decoder_rs1_dep / rs2_dep  in  ROB_WIDTH  producer tag when not ready
- from_decoder_imm  in  32  sign-extended offset
- alu_cdb / lsb_cdb  in  1  broadcast valid
- alu_cdb_tag / lsb_cdb_tag  in  ROB_WIDTH  broadcast tag
- alu_cdb_data / lsb_cdb_data  in  32  broadcast value
- to_lsb  out  1  issue valid, one-cycle pulse
- to_lsb_op  out  4  op
- to_lsb_tag  out  ROB_WIDTH  tag
- to_lsb_address  out  32  rs1+imm
- to_lsb_wdata  out  32  rs2 (stores), 0 for loads
- to_decoder_full  out  1  fewer than 2 free entries

Function
REQ-005 Entry state: valid, op, tag, imm, and per operand rdy/val/dep.
REQ-006 Dispatch SHALL write the lowest-index invalid entry; dispatch while full is a decoder error, ignored, no state change.
REQ-007 Loads (op<5) SHALL set rs2 ready at dispatch regardless of input.
REQ-008 Each waiting operand SHALL capture data when alu_cdb or lsb_cdb tag equals dep; both matching same cycle: alu_cdb wins.
REQ-009 Dispatch operand whose dep matches a same-cycle broadcast SHALL store as ready with broadcast data.
REQ-010 Eligible entry: valid, rs1 ready, rs2 ready. Per cycle at most one issue: lowest-index eligible entry.
REQ-011 Issue SHALL register to_lsb=1 with fields next edge, invalidate entry same edge; to_lsb=0 otherwise.
REQ-012 Address SHALL be (rs1_val+imm) mod 2^32; no alignment check.
REQ-013 Latency without bypass: dispatch with both operands ready at edge t -> to_lsb high after edge t+1; wakeup at edge t -> issue after edge t+1.
REQ-014 Freed slot and new dispatch same edge: dispatch SHALL use lowest invalid entry before that edge's invalidation.
REQ-015 to_decoder_full SHALL be registered from post-edge count: 1 iff MRS_SIZE-count < 2.
REQ-016 clear SHALL invalidate all entries, drive to_lsb=0, to_decoder_full=0 next edge; same-cycle dispatch and broadcasts discarded.
REQ-017 rdy_in=0 SHALL hold all entries and outputs, ignoring all inputs; rst_in acts only when rdy_in=1.

Reset
REQ-018 rst_in SHALL clear all valid bits; to_lsb=0, to_decoder_full=0, op/tag/address/wdata=0.
REQ-019 Reset mid-wakeup SHALL discard pending broadcasts; no issue until new dispatch.

Configuration
REQ-020 Macro MRS_CDB_BYPASS_EN: defined -> eligibility and issued data SHALL include same-cycle broadcasts and same-cycle dispatch, cutting REQ-013 latency by one cycle (dispatch ready at edge t -> to_lsb after edge t); undefined -> eligibility uses stored state only, per REQ-013.

Verification
REQ-021 Reset, dispatch LW tag 3, rs1=0x1000 ready, imm=8 -> one to_lsb pulse, address 0x1008, op 4, tag 3, wdata 0.
REQ-022 Dispatch SW tag 5, rs1 ready 0x20, rs2 dep 2, imm -4; alu_cdb tag 2 data 0xDEADBEEF two cycles later -> issue address 0x1C, wdata 0xDEADBEEF.
REQ-023 Fill 4 entries all dep 7 -> to_decoder_full=1 after third dispatch; lsb_cdb tag 7 -> entries issue in index order 0..3, one per cycle, full drops.
REQ-024 alu_cdb and lsb_cdb both tag 1 (data 0x11, 0x22) same cycle to waiting entry -> captured 0x11.
REQ-025 Two waiting entries, clear asserted with matching broadcast -> no to_lsb ever, full=0, next dispatch lands in entry 0.
REQ-026 rdy_in low 3 cycles during pending wakeup broadcast -> no state change; issue resumes after rdy_in high.
